// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for N channels sharing one tri-state bus, with hold limit and a turnaround cycle.
// Optional bus keeper enabled by defining TRI_BUS_KEEPER_EN.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   gnt,
  output tri   [W-1:0]   bus,
  output logic           busy,
  output logic           timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [7:0]    hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand_idx;
  int unsigned   cand;
  logic [W-1:0]  owner_data;

  // First requester at or after ptr, searching upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr_q) + k) % N;
      cand_idx = IW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) owner_data = data_in[i*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        if (win_found) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          hold_d           = 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[owner_q] || hold_q == 8'(MAX_HOLD)) begin
          state_d   = TURN;
          gnt_d     = '0;
          hold_d    = '0;
          ptr_d     = (owner_q == IW'(N-1)) ? '0 : owner_q + 1'b1;
          // Only a forced release with the request still pending flags timeout.
          timeout_d = req[owner_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

`ifdef TRI_BUS_KEEPER_EN
  logic [W-1:0] keep_q, keep_d;

  always_comb begin
    keep_d = keep_q;
    if (busy) keep_d = owner_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) keep_q <= '0;
    else     keep_q <= keep_d;
  end

  assign bus = busy ? owner_data : keep_q;
`else
  assign bus = busy ? owner_data : {W{1'bz}};
`endif

endmodule
